// File: rtl/nrs_scheduler_rx_pkg.sv
// Shared constants for the NRS receive scheduler: FSM encoding, NRS symbol indices, sync subframes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nrs_sched_pkg;

  // FSM state encoding (legacy-compatible plain constants)
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_WAIT_EST = 3'd4;

  // NRS occupies the last two OFDM symbols of each slot
  localparam logic [2:0] NRS_L_FIRST  = 3'd5;
  localparam logic [2:0] NRS_L_SECOND = 3'd6;

  // Default subframes carrying the narrowband sync signals
  localparam int NPSS_SF_DEF = 5;
  localparam int NSSS_SF_DEF = 9;

  // Slot number of a run: two slots per subframe, second half of the runs uses the odd slot
  function automatic logic [4:0] nrs_slot(input logic [3:0] sf, input logic odd_slot);
    return {sf, odd_slot};
  endfunction

endpackage

// File: rtl/nrs_scheduler_rx_if.sv
// Bundle of the scheduler's strobes, run descriptor and status toward timing, generator and estimator.
// Latency: n/a (wiring only).
// Backpressure: none on the bus itself; est_ack is the estimator's release of the NRS buffer.
interface nrs_scheduler_rx_if;
  logic       sf_tick;
  logic       frame_start;
  logic       gen_start;
  logic [4:0] run_ns;
  logic [2:0] run_l;
  logic       first_run;
  logic       last_run;
  logic       gen_run_done;
  logic       sf_ready;
  logic       est_ack;
  logic [3:0] sf_idx;
  logic       overrun;

  // Scheduler side
  modport master (
    input  sf_tick, frame_start, gen_run_done, est_ack,
    output gen_start, run_ns, run_l, first_run, last_run, sf_ready, sf_idx, overrun
  );

  // Environment side (timing, generator, estimator)
  modport slave (
    output sf_tick, frame_start, gen_run_done, est_ack,
    input  gen_start, run_ns, run_l, first_run, last_run, sf_ready, sf_idx, overrun
  );
endinterface

// File: rtl/nrs_scheduler_rx_sf_counter.sv
// Tracks subframe index and radio-frame parity from the subframe strobe.
// Latency: sf_idx/odd_frame update on the clock edge that samples sf_tick.
// Backpressure: none; every sf_tick is counted regardless of scheduler state.
module nrs_sf_counter
  import nrs_sched_pkg::*;
#(
  parameter int SF_PER_FRAME = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sf_tick,
  input  logic       frame_start,
  output logic [3:0] sf_idx,
  output logic       odd_frame
);

  localparam logic [3:0] SF_LAST = 4'(SF_PER_FRAME - 1);

  // Advance on every tick; frame_start realigns to subframe 0 of an even frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sf_idx    <= 4'd0;
      odd_frame <= 1'b0;
    end else if (sf_tick) begin
      if (frame_start) begin
        sf_idx    <= 4'd0;
        odd_frame <= 1'b0;
      end else if (sf_idx == SF_LAST) begin
        sf_idx    <= 4'd0;
        odd_frame <= ~odd_frame;
      end else begin
        sf_idx    <= sf_idx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/nrs_scheduler_rx.sv
// Schedules NRS generator runs per subframe and hands the filled buffer to the estimator.
// Latency: sf_tick at T -> gen_start at T+2; sf_ready the cycle after the last gen_run_done.
// Backpressure: estimator holds the buffer until est_ack; ticks arriving while busy set sticky overrun.
// Build option: NRS_SCHED_SKIP_SYNC_EN skips NPSS subframes and NSSS subframes of even frames.
module nrs_scheduler_rx
  import nrs_sched_pkg::*;
#(
  parameter int SF_PER_FRAME = 10,
  parameter int RUNS_PER_SF  = 4,
  parameter int NPSS_SF      = NPSS_SF_DEF,
  parameter int NSSS_SF      = NSSS_SF_DEF
) (
  input  logic               clk,
  input  logic               rst,
  nrs_scheduler_rx_if.master bus
);

`ifdef NRS_SCHED_SKIP_SYNC_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  // Counter must be at least 2 bits: bit 1 selects the slot, bit 0 the symbol
  localparam int             CW       = (RUNS_PER_SF > 4) ? $clog2(RUNS_PER_SF) : 2;
  localparam logic [CW-1:0]  LAST_RUN = CW'(RUNS_PER_SF - 1);

  logic [2:0]    state, state_nx;
  logic [CW-1:0] run_cnt;
  logic [3:0]    cur_sf;
  logic [3:0]    sf_idx;
  logic          odd_frame;
  logic          overrun_q;
  logic          sched_skip;
  logic          run_active;

  nrs_sf_counter #(
    .SF_PER_FRAME (SF_PER_FRAME)
  ) u_sf_counter (
    .clk         (clk),
    .rst         (rst),
    .sf_tick     (bus.sf_tick),
    .frame_start (bus.frame_start),
    .sf_idx      (sf_idx),
    .odd_frame   (odd_frame)
  );

  assign sched_skip = SKIP_EN && ((sf_idx == 4'(NPSS_SF)) ||
                                  ((sf_idx == 4'(NSSS_SF)) && !odd_frame));

  // Next-state decision for the per-subframe FSM
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (bus.sf_tick) state_nx = ST_CHECK;
      ST_CHECK:    state_nx = sched_skip ? ST_IDLE : ST_START;
      ST_START:    state_nx = ST_RUN;
      ST_RUN:      if (bus.gen_run_done && (run_cnt == LAST_RUN)) state_nx = ST_WAIT_EST;
      ST_WAIT_EST: if (bus.est_ack) state_nx = bus.sf_tick ? ST_CHECK : ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Run counter: zero through CHECK/START, counts completed runs while in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else if ((state == ST_CHECK) || (state == ST_START)) begin
      run_cnt <= '0;
    end else if ((state == ST_RUN) && bus.gen_run_done && (run_cnt != LAST_RUN)) begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

  // Latch the scheduled subframe so a late tick advancing sf_idx cannot disturb run_ns
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cur_sf <= 4'd0;
    else if (state == ST_CHECK) cur_sf <= sf_idx;
  end

  // Sticky overrun: a tick the FSM cannot accept; only the est_ack+tick handoff is legal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (bus.sf_tick && (state != ST_IDLE) &&
                 !((state == ST_WAIT_EST) && bus.est_ack)) begin
      overrun_q <= 1'b1;
    end
  end

  assign run_active    = (state == ST_START) || (state == ST_RUN);
  assign bus.gen_start = (state == ST_START);
  assign bus.run_ns    = run_active ? nrs_slot(cur_sf, run_cnt[1]) : 5'd0;
  assign bus.run_l     = run_active ? (run_cnt[0] ? NRS_L_SECOND : NRS_L_FIRST) : 3'd0;
  assign bus.first_run = run_active && (run_cnt == '0);
  assign bus.last_run  = run_active && (run_cnt == LAST_RUN);
  assign bus.sf_ready  = (state == ST_WAIT_EST);
  assign bus.sf_idx    = sf_idx;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_nrs_scheduler_rx.sv
// Self-checking bench for nrs_scheduler_rx against a subframe-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nrs_scheduler_rx;
  import nrs_sched_pkg::*;

  localparam int SFPF = 10;
  localparam int RPS  = 4;
  localparam int NPSS = 5;
  localparam int NSSS = 9;
`ifdef NRS_SCHED_SKIP_SYNC_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nrs_scheduler_rx_if bus ();

  nrs_scheduler_rx #(
    .SF_PER_FRAME (SFPF),
    .RUNS_PER_SF  (RPS),
    .NPSS_SF      (NPSS),
    .NSSS_SF      (NSSS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: subframe index, frame parity, sticky overrun
  int m_sf  = 0;
  int m_par = 0;
  bit m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_sched(input int sf, input int par);
    return !SKIP_EN || !((sf == NPSS) || ((sf == NSSS) && (par == 0)));
  endfunction

  function automatic void m_advance(input bit fs);
    if (fs) begin
      m_sf  = 0;
      m_par = 0;
    end else if (m_sf == SFPF - 1) begin
      m_sf  = 0;
      m_par = 1 - m_par;
    end else begin
      m_sf++;
    end
  endfunction

  task automatic tick(input bit fs);
    m_advance(fs);
    bus.sf_tick     = 1'b1;
    bus.frame_start = fs;
    step();
    bus.sf_tick     = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gen_start"}, bus.gen_start, 0);
    check({tag, "_run_ns"},    bus.run_ns,    0);
    check({tag, "_run_l"},     bus.run_l,     0);
    check({tag, "_first"},     bus.first_run, 0);
    check({tag, "_last"},      bus.last_run,  0);
    check({tag, "_sf_ready"},  bus.sf_ready,  0);
  endtask

  task automatic check_run(input int k, input int sf);
    check("run_ns",    bus.run_ns,    2 * sf + k / 2);
    check("run_l",     bus.run_l,     5 + k % 2);
    check("first_run", bus.first_run, (k == 0) ? 1 : 0);
    check("last_run",  bus.last_run,  (k == RPS - 1) ? 1 : 0);
    check("sf_ready_in_run", bus.sf_ready, 0);
  endtask

  // After a tick: checks T+1/T+2; when scheduled, leaves the bench in RUN with run 0 pending
  task automatic start_sf(input bit fs, output bit sch, output int sf);
    tick(fs);
    sf  = m_sf;
    sch = m_sched(m_sf, m_par);
    check("gen_start_T1", bus.gen_start, 0);
    check("sf_idx", bus.sf_idx, m_sf);
    step();
    if (!sch) begin
      check_quiet("skip");
    end else begin
      check("gen_start_T2", bus.gen_start, 1);
      check_run(0, sf);
      step();
      check("gen_start_one_cycle", bus.gen_start, 0);
      check_run(0, sf);
    end
  endtask

  // Wait a gap then complete run k; outputs then describe run k+1 (or WAIT_EST)
  task automatic do_run(input int k, input int sf, input int gap);
    repeat (gap) step();
    check_run(k, sf);
    bus.gen_run_done = 1'b1;
    step();
    bus.gen_run_done = 1'b0;
    if (k < RPS - 1) check_run(k + 1, sf);
  endtask

  task automatic finish_sf(input int ack_max);
    check("sf_ready_set", bus.sf_ready, 1);
    check("run_ns_wait",  bus.run_ns, 0);
    repeat ($urandom_range(ack_max, 0)) step();
    check("sf_ready_hold", bus.sf_ready, 1);
    bus.est_ack = 1'b1;
    step();
    bus.est_ack = 1'b0;
    check("sf_ready_clr", bus.sf_ready, 0);
    check("overrun", bus.overrun, m_ovr);
  endtask

  initial begin
    bit sch;
    int sf;

    rst              = 1'b1;
    bus.sf_tick      = 1'b0;
    bus.frame_start  = 1'b0;
    bus.gen_run_done = 1'b0;
    bus.est_ack      = 1'b0;
    repeat (2) step();
    check_quiet("reset");
    check("reset_sf_idx",  bus.sf_idx,  0);
    check("reset_overrun", bus.overrun, 0);
    rst = 1'b0;
    step();

    // Frame start with runs spaced 1600 cycles apart
    start_sf(1'b1, sch, sf);
    for (int k = 0; k < RPS; k++) do_run(k, sf, 1599);
    finish_sf(3);

    // Randomized walk across two frames: covers wrap, parity and sync subframes
    for (int i = 0; i < 22; i++) begin
      repeat ($urandom_range(3, 0)) step();
      start_sf(1'b0, sch, sf);
      if (sch) begin
        for (int k = 0; k < RPS; k++) do_run(k, sf, $urandom_range(6, 0));
        finish_sf(5);
      end else begin
        check("skip_overrun", bus.overrun, m_ovr);
      end
    end

    // est_ack outside WAIT_EST ignored; tick during RUN raises overrun, subframe completes
    start_sf(1'b1, sch, sf);
    do_run(0, sf, 2);
    bus.est_ack = 1'b1;
    step();
    bus.est_ack = 1'b0;
    check_run(1, sf);
    do_run(1, sf, 1);
    tick(1'b0);
    m_ovr = 1'b1;
    check("overrun_set", bus.overrun, 1);
    check("overrun_sf_idx", bus.sf_idx, m_sf);
    check_run(2, sf);
    do_run(2, sf, 2);
    do_run(3, sf, 2);
    finish_sf(2);
    repeat (4) step();
    check("overrun_sticky", bus.overrun, 1);

    // Asynchronous reset mid-RUN abandons the subframe
    start_sf(1'b1, sch, sf);
    do_run(0, sf, 1);
    do_run(1, sf, 1);
    #2;
    rst = 1'b1;
    #1;
    m_sf  = 0;
    m_par = 0;
    m_ovr = 1'b0;
    check_quiet("async_rst");
    check("async_rst_overrun", bus.overrun, 0);
    check("async_rst_sf_idx",  bus.sf_idx,  0);
    step();
    #3;
    rst = 1'b0;
    step();
    bus.gen_run_done = 1'b1;
    step();
    bus.gen_run_done = 1'b0;
    repeat (3) step();
    check_quiet("post_rst");

    // Next tick restarts at run 0; est_ack with sf_tick hands off straight to CHECK
    start_sf(1'b1, sch, sf);
    check("post_rst_first", bus.first_run, 1);
    for (int k = 0; k < RPS; k++) do_run(k, sf, $urandom_range(4, 0));
    check("handoff_ready", bus.sf_ready, 1);
    m_advance(1'b0);
    bus.est_ack = 1'b1;
    bus.sf_tick = 1'b1;
    step();
    bus.est_ack = 1'b0;
    bus.sf_tick = 1'b0;
    check("handoff_check_ready", bus.sf_ready, 0);
    check("handoff_check_gen",   bus.gen_start, 0);
    check("handoff_overrun",     bus.overrun, 0);
    check("handoff_sf_idx",      bus.sf_idx, m_sf);
    step();
    check("handoff_gen_start", bus.gen_start, 1);
    check_run(0, m_sf);
    sf = m_sf;
    step();
    for (int k = 0; k < RPS; k++) do_run(k, sf, $urandom_range(4, 0));
    finish_sf(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
